// File: rtl/mul_rr_arbiter_pkg.sv
// Shared constants and pipeline payload types for the round-robin int8 multiplier arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mul_rr_arbiter_pkg;

  localparam int INT8_MAX = 127;
  localparam int INT8_MIN = -128;

  // Widest requester index supported (NREQ up to 16); narrower ids are zero-extended.
  localparam int ID_MAXW = 4;

  typedef struct packed {
    logic [ID_MAXW-1:0] id;
    logic signed [7:0]  a;
    logic signed [7:0]  b;
  } s1_pay_t;

  typedef struct packed {
    logic [ID_MAXW-1:0] id;
    logic signed [7:0]  product;
    logic               sat;
  } s2_pay_t;

endpackage

// File: rtl/mul_rr_arbiter_mul.sv
// Signed 8x8 multiply clamped to int8, flagging when the clamp was applied.
// Latency: purely combinational.
// Backpressure: none, no state.
module int8_sat_mul
  import mul_rr_arbiter_pkg::*;
(
  input  logic signed [7:0] a,
  input  logic signed [7:0] b,
  output logic signed [7:0] product,
  output logic              sat
);

  logic signed [15:0] full;

  // Full-precision product, then clamp into the int8 range.
  always_comb begin
    full    = 16'(a) * 16'(b);
    product = full[7:0];
    sat     = 1'b0;
    if (full > 16'(INT8_MAX)) begin
      product = 8'(INT8_MAX);
      sat     = 1'b1;
    end else if (full < 16'(INT8_MIN)) begin
      product = 8'(INT8_MIN);
      sat     = 1'b1;
    end
  end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one int8 saturating multiplier among NREQ requesters.
// Latency: accept in cycle N -> rsp_valid in cycle N+2; one product per cycle sustained.
// Backpressure: rsp_ready low freezes S2; S1 then fills and req_ready drops to zero.
module mul_rr_arbiter
  import mul_rr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*8-1:0]      req_a,
  input  logic [NREQ*8-1:0]      req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic signed [7:0]      rsp_product,
  output logic                   rsp_sat,
  output logic                   busy,
  output logic [15:0]            sat_count
);

  logic           s1_valid;
  s1_pay_t        s1;
  logic           s2_valid;
  s2_pay_t        s2;
  logic [IDW-1:0] ptr;

  logic           adv1;
  logic           adv2;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   search;
  logic signed [7:0] mul_p;
  logic           mul_sat;

  // First set bit of v at or after p, wrapping; MSB of the result flags a hit.
  function automatic logic [IDW:0] rr_search(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
    logic [IDW:0]   res;
    logic [IDW-1:0] idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(p) + k) % NREQ);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign adv2 = !s2_valid || rsp_ready;
  assign adv1 = !s1_valid || adv2;

  assign search  = rr_search(req_valid, ptr);
  assign gnt_vld = search[IDW];
  assign gnt_id  = search[IDW-1:0];

  // Grant is offered only to the winner, only when S1 can take it, never while in reset.
  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_id] = adv1 && rst_n;
  end

  // S1 capture of the winning operand pair; pointer moves past the winner on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      ptr      <= '0;
    end else if (adv1) begin
      s1_valid <= gnt_vld;
      if (gnt_vld) begin
        s1.id <= ID_MAXW'(gnt_id);
        s1.a  <= req_a[{gnt_id, 3'b000} +: 8];
        s1.b  <= req_b[{gnt_id, 3'b000} +: 8];
        ptr   <= IDW'((int'(gnt_id) + 1) % NREQ);
      end
    end
  end

  int8_sat_mul u_mul (
    .a       (s1.a),
    .b       (s1.b),
    .product (mul_p),
    .sat     (mul_sat)
  );

  // S2 takes the clamped product; payload only updates with real data so idle outputs stay quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2.id      <= s1.id;
        s2.product <= mul_p;
        s2.sat     <= mul_sat;
      end
    end
  end

  // Count clamped products as they are handed off, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (s2_valid && rsp_ready && s2.sat && sat_count != 16'hFFFF) begin
      sat_count <= sat_count + 16'd1;
    end
  end

  assign rsp_valid   = s2_valid;
  assign rsp_id      = IDW'(s2.id);
  assign rsp_product = s2.product;
  assign rsp_sat     = s2.sat;
  assign busy        = s1_valid || s2_valid;

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomized and directed bench for mul_rr_arbiter against a queue-based reference model.
// Latency: n/a.
// Backpressure: rsp_ready driven by the bench, held low or randomized per phase.
module tb_mul_rr_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_product;
  logic              rsp_sat;
  logic              busy;
  logic [15:0]       sat_count;

  mul_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_sat     (rsp_sat),
    .busy        (busy),
    .sat_count   (sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [7:0] a;
    logic signed [7:0] b;
  } pair_t;

  typedef struct {
    int         id;
    logic [7:0] prod;
    logic       sat;
    int         acc;
  } exp_t;

  // Reference state: per-requester pending pairs, pairs in flight in accept order.
  pair_t     strm [NREQ][$];
  logic      act  [NREQ];
  exp_t      q    [$];
  int        mptr;
  logic [15:0] msat;
  int        cyc;
  int        pct;
  int        accepts;
  int        handshakes;
  int        checks;
  int        errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_mul(input int id, input pair_t p, input int acc);
    exp_t e;
    int   full;
    full  = int'(p.a) * int'(p.b);
    e.id  = id;
    e.acc = acc;
    e.sat = 1'b0;
    if (full > 127) begin
      full  = 127;
      e.sat = 1'b1;
    end else if (full < -128) begin
      full  = -128;
      e.sat = 1'b1;
    end
    e.prod = full[7:0];
    return e;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (act[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic all_empty();
    logic e;
    e = (q.size() == 0);
    for (int i = 0; i < NREQ; i++) if (strm[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance the model, step to next posedge+1.
  task automatic run_cycle(input logic rdy);
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv;
    for (int i = 0; i < NREQ; i++) begin
      if (!act[i] && strm[i].size() > 0 && $urandom_range(99) < pct) act[i] = 1'b1;
      req_valid[i]     = act[i];
      req_a[8*i +: 8]  = act[i] ? strm[i][0].a : 8'h00;
      req_b[8*i +: 8]  = act[i] ? strm[i][0].b : 8'h00;
    end
    rsp_ready = rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0 && (q.size() < 2 || rdy)) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    exp_rv = (q.size() > 0) && (q[0].acc <= cyc - 2);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("busy", busy, q.size() > 0);
    chk("sat_count", sat_count, msat);
    if (exp_rv) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_product", rsp_product, q[0].prod);
      chk("rsp_sat", rsp_sat, q[0].sat);
      if (rdy) begin
        if (q[0].sat && msat != 16'hFFFF) msat++;
        void'(q.pop_front());
        handshakes++;
      end
    end
    if (exp_rdy != '0) begin
      q.push_back(model_mul(g, strm[g][0], cyc));
      void'(strm[g].pop_front());
      act[g] = 1'b0;
      mptr   = (g + 1) % NREQ;
      accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input logic random_rdy);
    for (int t = 0; t < 2000; t++) begin
      if (all_empty()) break;
      run_cycle(random_rdy ? 1'($urandom_range(1)) : 1'b1);
    end
    chk("drain_done", all_empty(), 1'b1);
  endtask

  task automatic push_pair(input int id, input int a, input int b);
    pair_t p;
    p.a = 8'(a);
    p.b = 8'(b);
    strm[id].push_back(p);
  endtask

  initial begin
    int base;
    checks = 0; errors = 0; cyc = 0; mptr = 0; msat = '0;
    accepts = 0; handshakes = 0; pct = 100;
    for (int i = 0; i < NREQ; i++) act[i] = 1'b0;

    // Reset state, with every requester asserting valid.
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '1; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_product", rsp_product, 0);
    chk("rst_rsp_sat", rsp_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat_count", sat_count, 0);
    rst_n = 1'b1; req_valid = '0;
    @(posedge clk);
    #1;

    // Single request from requester 2.
    push_pair(2, 5, -7);
    drain(1'b0);

    // Saturation corners.
    push_pair(0, 100, 100);
    push_pair(0, -128, -128);
    push_pair(0, -128, 127);
    push_pair(0, 11, -11);
    drain(1'b0);
    chk("sat_count_after_corners", sat_count, 3);

    // Fairness: all requesters continuously valid.
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < NREQ; i++) push_pair(i, i + 1, 1);
    base = handshakes;
    repeat (8 * NREQ + 2) run_cycle(1'b1);
    chk("fair_one_per_cycle", handshakes - base, 8 * NREQ);
    drain(1'b0);

    // Backpressure: stalled output admits exactly two pairs.
    for (int n = 0; n < 6; n++) push_pair(1, n + 3, -(n + 2));
    base = accepts;
    repeat (5) run_cycle(1'b0);
    chk("bp_accepts", accepts - base, 2);
    drain(1'b0);

    // Randomized traffic and backpressure.
    pct = 50;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 20; n++)
        push_pair(i, $urandom_range(255), ($urandom_range(3) == 0) ? 128 : $urandom_range(255));
    drain(1'b1);

    // Reset with both stages full.
    pct = 100;
    for (int i = 0; i < NREQ; i++)
      for (int n = 0; n < 4; n++) push_pair(i, 9 * i + n - 8, n - 2);
    run_cycle(1'b0);
    run_cycle(1'b0);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_id", rsp_id, 0);
    chk("mid_rst_rsp_product", rsp_product, 0);
    chk("mid_rst_rsp_sat", rsp_sat, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sat_count", sat_count, 0);
    q.delete();
    msat = '0;
    mptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc += 2;
    drain(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
